// File: rtl/mips_state_dumper_if.sv
// ---------------------------------------------------------------------------
// mips_state_dumper_if
//   Byte-stream link between the state dumper and the host-link UART TX.
//   A byte moves on a rising clock edge when tx_valid and tx_ready are both 1.
//
//   tx_data   8  stream byte (source -> sink)
//   tx_valid  1  byte valid   (source -> sink)
//   tx_ready  1  sink ready   (sink -> source)
//
//   modport master : byte source (the dumper)
//   modport slave  : byte sink   (UART TX or testbench)
// ---------------------------------------------------------------------------
interface mips_state_dumper_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/mips_state_dumper.sv
// ---------------------------------------------------------------------------
// mips_state_dumper
//   On a rising edge of the core halt flag, reads the cycle counter, the PC,
//   r0..r31 and mem[0 .. MEM_DUMP_WORDS-1] through the core read ports and
//   streams them as one frame:
//     HEADER_BYTE, 4 bytes per word (MSB first), XOR checksum byte.
//   The checksum covers every byte after the header.
//
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   i_halt      in   core halt flag
//   i_pc        in   live PC, latched when the PC word is captured
//   o_reg_addr  out  register-file read address (data one cycle later)
//   i_reg_data  in   register-file read data
//   o_mem_addr  out  data-memory word read address (data one cycle later)
//   i_mem_data  in   data-memory read data
//   tx          mst  byte stream towards the UART TX
//   o_busy      out  high from HEADER through CHECKSUM
//   o_done      out  high in DONE
//
//   DATA_WIDTH is fixed at 32: the byte slicer and counter assume 4 bytes.
// ---------------------------------------------------------------------------
module mips_state_dumper #(
  parameter int         DATA_WIDTH     = 32,
  parameter int         MEM_ADDR_WIDTH = 8,
  parameter int         MEM_DUMP_WORDS = 32,
  parameter logic [7:0] HEADER_BYTE    = 8'hA5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_halt,
  input  logic [DATA_WIDTH-1:0]     i_pc,
  output logic [4:0]                o_reg_addr,
  input  logic [DATA_WIDTH-1:0]     i_reg_data,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0]     i_mem_data,
  mips_state_dumper_if.master       tx,
  output logic                      o_busy,
  output logic                      o_done
);

  // Word numbering inside a frame: 0 = cycle count, 1 = PC,
  // 2..33 = r0..r31, 34.. = mem[0..].
  localparam int LAST_WORD_I = 33 + MEM_DUMP_WORDS;
  localparam int WORD_W      = $clog2(LAST_WORD_I + 1);

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t W_PC   = word_t'(1);
  localparam word_t W_REG0 = word_t'(2);
  localparam word_t W_MEM0 = word_t'(34);
  localparam word_t W_LAST = word_t'(LAST_WORD_I);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_ADDR,
    S_CAPTURE,
    S_SEND,
    S_CHECKSUM,
    S_DONE
  } state_t;

  state_t                state, state_next;
  logic                  halt_q;
  logic [31:0]           cycle_cnt;
  word_t                 word_idx;
  word_t                 addr_word;
  logic [1:0]            byte_idx;
  logic [DATA_WIDTH-1:0] shift_buf;
  logic [7:0]            csum;
  logic                  start;

  assign start     = i_halt && !halt_q;
  // Word whose address is presented on the next ADDR entry.
  assign addr_word = (state == S_HEADER) ? '0 : word_idx + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // NOTE: every output and next-state variable gets a default before the
  // case, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    tx.tx_valid = 1'b0;
    tx.tx_data  = '0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_HEADER;
      end
      S_HEADER: begin
        o_busy      = 1'b1;
        tx.tx_valid = 1'b1;
        tx.tx_data  = HEADER_BYTE;
        if (tx.tx_ready) state_next = S_ADDR;
      end
      S_ADDR: begin
        o_busy     = 1'b1;
        state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        o_busy     = 1'b1;
        state_next = S_SEND;
      end
      S_SEND: begin
        o_busy      = 1'b1;
        tx.tx_valid = 1'b1;
        tx.tx_data  = shift_buf[DATA_WIDTH-1 -: 8];
        if (tx.tx_ready && byte_idx == 2'd3)
          state_next = (word_idx == W_LAST) ? S_CHECKSUM : S_ADDR;
      end
      S_CHECKSUM: begin
        o_busy      = 1'b1;
        tx.tx_valid = 1'b1;
        tx.tx_data  = csum;
        if (tx.tx_ready) state_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        if (!i_halt) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halt_q     <= 1'b0;
      cycle_cnt  <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      shift_buf  <= '0;
      csum       <= '0;
      o_reg_addr <= '0;
      o_mem_addr <= '0;
    end else begin
      halt_q <= i_halt;

      // Running-cycle count: frozen while halted, sticks at all-ones.
      if (!i_halt && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;

      if (state == S_IDLE) csum <= '0;

      // Addresses change only on entry to ADDR, so they hold through
      // CAPTURE and keep their last value for the rest of the frame.
      if (state != S_ADDR && state_next == S_ADDR) begin
        word_idx <= addr_word;
        if (addr_word >= W_MEM0)
          o_mem_addr <= MEM_ADDR_WIDTH'(addr_word - W_MEM0);
        else if (addr_word >= W_REG0)
          o_reg_addr <= 5'(addr_word - W_REG0);
      end

      if (state == S_CAPTURE) begin
        if (word_idx == '0)          shift_buf <= cycle_cnt;
        else if (word_idx == W_PC)   shift_buf <= i_pc;
        else if (word_idx < W_MEM0)  shift_buf <= i_reg_data;
        else                         shift_buf <= i_mem_data;
      end

      // byte_idx wraps to 0 after the 4th byte, ready for the next word.
      if (state == S_SEND && tx.tx_ready) begin
        shift_buf <= shift_buf << 8;
        byte_idx  <= byte_idx + 2'd1;
        csum      <= csum ^ shift_buf[DATA_WIDTH-1 -: 8];
      end
    end
  end

endmodule

// File: tb/tb_mips_state_dumper.sv
// ---------------------------------------------------------------------------
// tb_mips_state_dumper
//   Bench for mips_state_dumper. Holds a register file and data memory with
//   one-cycle read latency, drives the sink ready line in several patterns,
//   records every transferred byte, and compares each frame against one
//   assembled from the architectural state it presented.
// ---------------------------------------------------------------------------
module tb_mips_state_dumper;
  localparam int MEM_ADDR_WIDTH = 8;
  localparam int MEM_DUMP_WORDS = 32;
  localparam int FRAME_LEN      = 138 + 4 * MEM_DUMP_WORDS;
  localparam int FRAME_CYCLES   = 2 + 6 * (34 + MEM_DUMP_WORDS);

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      i_halt;
  logic [31:0]               i_pc;
  logic [4:0]                o_reg_addr;
  logic [31:0]               i_reg_data;
  logic [MEM_ADDR_WIDTH-1:0] o_mem_addr;
  logic [31:0]               i_mem_data;
  logic                      o_busy;
  logic                      o_done;

  mips_state_dumper_if tx ();

  always #5 clk = ~clk;

  mips_state_dumper #(
    .DATA_WIDTH     (32),
    .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
    .MEM_DUMP_WORDS (MEM_DUMP_WORDS),
    .HEADER_BYTE    (8'hA5)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_halt     (i_halt),
    .i_pc       (i_pc),
    .o_reg_addr (o_reg_addr),
    .i_reg_data (i_reg_data),
    .o_mem_addr (o_mem_addr),
    .i_mem_data (i_mem_data),
    .tx         (tx),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  int n_assert;
  int n_fail;

  // Architectural state and synchronous read ports.
  logic [31:0] regs [32];
  logic [31:0] mem  [MEM_DUMP_WORDS];

  always @(posedge clk) begin
    i_reg_data <= regs[o_reg_addr];
    i_mem_data <= (o_mem_addr < 8'd32) ? mem[o_mem_addr[4:0]] : 32'hDEAD_BEEF;
  end

  // Running-cycle reference: clock edges seen with the core not halted.
  logic [31:0] running_cycles;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) running_cycles = 0;
    else if (!i_halt && running_cycles != 32'hFFFF_FFFF)
      running_cycles = running_cycles + 1;
  end

  // Sink ready pattern: 0 = always, 1 = every 3rd cycle, 2 = random.
  int          ready_mode;
  int unsigned tb_cyc;
  always @(posedge clk) begin
    #1;
    tb_cyc++;
    case (ready_mode)
      0:       tx.tx_ready = 1'b1;
      1:       tx.tx_ready = (tb_cyc % 3 == 0);
      default: tx.tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Byte recorder and hold-while-stalled watcher, sampled mid-cycle.
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  int         stab_err;
  int         stall_cnt;
  logic       hold_pending;
  logic [7:0] hold_data;

  always @(negedge clk) begin
    if (!reset_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending && !(tx.tx_valid === 1'b1 && tx.tx_data === hold_data))
        stab_err++;
      hold_pending = tx.tx_valid && !tx.tx_ready;
      if (hold_pending) stall_cnt++;
      hold_data = tx.tx_data;
      if (tx.tx_valid && tx.tx_ready) rx_q.push_back(tx.tx_data);
    end
  end

  function automatic logic [7:0] rx_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 8'hxx;
  endfunction

  function automatic logic [31:0] rx_word(input int first);
    return {rx_at(first), rx_at(first + 1), rx_at(first + 2), rx_at(first + 3)};
  endfunction

  function automatic int frame_errors();
    int e;
    e = 0;
    if (rx_q.size() != exp_q.size()) e++;
    for (int i = 0; i < exp_q.size(); i++)
      if (rx_at(i) !== exp_q[i]) e++;
    return e;
  endfunction

  // Frame the bench expects for the given counter/PC and current state.
  task automatic build_expected(input logic [31:0] cnt, input logic [31:0] pc);
    logic [31:0] w;
    logic [7:0]  cs;
    cs = '0;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 34 + MEM_DUMP_WORDS; i++) begin
      if (i == 0)      w = cnt;
      else if (i == 1) w = pc;
      else if (i < 34) w = regs[i - 2];
      else             w = mem[i - 34];
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(w[8*b +: 8]);
        cs ^= w[8*b +: 8];
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic randomize_state();
    regs[0] = '0;
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    for (int i = 0; i < MEM_DUMP_WORDS; i++) mem[i] = $urandom;
  endtask

  // Called at posedge+1; the next edge is the start edge.
  task automatic start_frame();
    i_pc = $urandom;
    rx_q.delete();
    i_halt = 1'b1;
    build_expected(running_cycles, i_pc);
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (o_done !== 1'b1 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    n_assert++;
    if (o_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: o_done=%b after %0d cycles, want 1", name, o_done, k);
    end
  endtask

  task automatic wait_bytes(input string name, input int n);
    int k;
    k = 0;
    while (rx_q.size() < n && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    n_assert++;
    if (rx_q.size() < n) begin
      n_fail++;
      $display("FAIL %s_bytes: got %0d bytes, want %0d", name, rx_q.size(), n);
    end
  endtask

  task automatic expect_frame(input string name);
    int e;
    e = frame_errors();
    n_assert++;
    if (e != 0) begin
      n_fail++;
      $display("FAIL %s_frame: %0d bad bytes, length %0d, want 0 bad and length %0d",
               name, e, rx_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    int bad;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;                 // i_halt already high
    @(posedge clk); #1;
    n_assert++;
    if ({o_busy, tx.tx_valid, tx.tx_data} !== {1'b1, 1'b1, 8'hA5}) begin
      n_fail++;
      $display("FAIL halt_after_reset: busy/valid/data=%b/%b/%h, want 1/1/a5",
               o_busy, tx.tx_valid, tx.tx_data);
    end
    repeat (20) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    n_assert++;
    if ({tx.tx_data, tx.tx_valid, o_reg_addr, o_mem_addr, o_busy, o_done} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: data=%h valid=%b reg=%h mem=%h busy=%b done=%b, want all 0",
               tx.tx_data, tx.tx_valid, o_reg_addr, o_mem_addr, o_busy, o_done);
    end
    i_halt = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (tx.tx_valid !== 1'b0 || o_busy !== 1'b0) bad++;
    end
    n_assert++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_after_reset: %0d cycles with valid/busy set, want 0", bad);
    end
  endtask

  task automatic test_nominal();
    int          k;
    int          offs [4] = '{1, 25, 33, 137};
    logic [31:0] vals [4] = '{32'h0000_005A, 32'h0000_001E, 32'hFFFF_FFE1, 32'h1234_5678};
    logic [7:0]  cs;
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    repeat (90) begin @(posedge clk); #1; end
    for (int i = 0; i < 32; i++) regs[i] = '0;
    regs[1] = 32'd10; regs[2] = 32'd20; regs[4] = 32'd30; regs[6] = -32'sd31;
    for (int i = 0; i < MEM_DUMP_WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h1234_5678;
    start_frame();
    @(posedge clk); #1;
    n_assert++;
    if ({o_busy, tx.tx_valid, tx.tx_data} !== {1'b1, 1'b1, 8'hA5}) begin
      n_fail++;
      $display("FAIL header_after_start: busy/valid/data=%b/%b/%h, want 1/1/a5",
               o_busy, tx.tx_valid, tx.tx_data);
    end
    k = 0;
    while (o_done !== 1'b1 && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    n_assert++;
    if (k != FRAME_CYCLES) begin
      n_fail++;
      $display("FAIL done_latency: o_done after %0d cycles, want %0d", k, FRAME_CYCLES);
    end
    expect_frame("nominal");
    n_assert++;
    if (rx_at(0) !== 8'hA5) begin
      n_fail++;
      $display("FAIL nominal_header: got %h, want a5", rx_at(0));
    end
    for (int i = 0; i < 4; i++) begin
      n_assert++;
      if (rx_word(offs[i]) !== vals[i]) begin
        n_fail++;
        $display("FAIL nominal_word_at_%0d: got %h, want %h", offs[i], rx_word(offs[i]), vals[i]);
      end
    end
    cs = '0;
    for (int i = 1; i < FRAME_LEN - 1; i++) cs ^= rx_at(i);
    n_assert++;
    if (rx_at(FRAME_LEN - 1) !== cs) begin
      n_fail++;
      $display("FAIL nominal_checksum: got %h, want %h", rx_at(FRAME_LEN - 1), cs);
    end
    i_halt = 1'b0;
    @(posedge clk); #1;
    n_assert++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_release: done=%b busy=%b, want 0/0", o_done, o_busy);
    end
  endtask

  task automatic test_backpressure();
    for (int m = 1; m <= 2; m++) begin
      ready_mode = m;
      randomize_state();
      repeat (3) begin @(posedge clk); #1; end
      stab_err  = 0;
      stall_cnt = 0;
      start_frame();
      wait_done($sformatf("bp%0d", m), 8000);
      expect_frame($sformatf("bp%0d", m));
      n_assert++;
      if (stab_err != 0 || stall_cnt == 0) begin
        n_fail++;
        $display("FAIL bp%0d_hold: %0d unstable stalls of %0d, want 0 of >0", m, stab_err, stall_cnt);
      end
      i_halt = 1'b0;
      @(posedge clk); #1;
    end
    ready_mode = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_halt_drop();
    int bad;
    randomize_state();
    start_frame();
    wait_bytes("drop", 40);
    i_halt = 1'b0;
    wait_done("drop", 2000);
    expect_frame("drop");
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (o_done !== 1'b0 || o_busy !== 1'b0 || tx.tx_valid !== 1'b0) bad++;
    end
    n_assert++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL drop_done_pulse: %0d cycles not idle after one-cycle DONE, want 0", bad);
    end
  endtask

  task automatic test_mid_reset();
    randomize_state();
    start_frame();
    wait_bytes("midrst", 50);
    @(negedge clk); #2 reset_n = 1'b0;
    #1;
    n_assert++;
    if (tx.tx_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: valid=%b busy=%b, want 0/0", tx.tx_valid, o_busy);
    end
    @(posedge clk); #1;
    rx_q.delete();
    build_expected(32'd0, i_pc);
    reset_n = 1'b1;                    // i_halt still high: new frame
    wait_done("midrst", 2000);
    expect_frame("midrst");
    n_assert++;
    if ({rx_at(0), rx_word(1)} !== 40'hA5_0000_0000) begin
      n_fail++;
      $display("FAIL midrst_head: got %h %h, want a5 00000000", rx_at(0), rx_word(1));
    end
  endtask

  task automatic test_rearm();
    int bad;
    i_halt = 1'b0;
    repeat (6) begin @(posedge clk); #1; end   // DONE exit edge + 5 cycles
    randomize_state();
    start_frame();
    wait_bytes("rearm", 20);
    i_halt = 1'b0;
    @(posedge clk); #1;
    i_halt = 1'b1;                             // edge while busy: ignored
    wait_done("rearm", 2000);
    expect_frame("rearm");
    n_assert++;
    if (rx_word(1) !== 32'd6) begin
      n_fail++;
      $display("FAIL rearm_count: got %h, want 00000006", rx_word(1));
    end
    i_halt = 1'b0;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (o_busy !== 1'b0 || tx.tx_valid !== 1'b0) bad++;
    end
    n_assert++;
    if (bad != 0 || rx_q.size() != FRAME_LEN) begin
      n_fail++;
      $display("FAIL rearm_no_extra: %0d busy cycles, %0d bytes, want 0 and %0d",
               bad, rx_q.size(), FRAME_LEN);
    end
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    ready_mode  = 0;
    tb_cyc      = 0;
    stab_err    = 0;
    stall_cnt   = 0;
    tx.tx_ready = 1'b1;
    reset_n     = 1'b0;
    i_halt      = 1'b1;
    i_pc        = 32'h0040_0000;
    randomize_state();

    test_reset();
    test_nominal();
    test_backpressure();
    test_halt_drop();
    test_mid_reset();
    test_rearm();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_state_dumper.md
# mips_state_dumper

Post-halt state transmitter for the MIPS pipeline. On each rising edge of the core's `halt` flag, it reads the cycle counter, PC, all 32 GPRs and the first `MEM_DUMP_WORDS` data-memory words through read ports. It streams them out as a framed byte sequence over a valid/ready byte interface, which feeds the host-link UART TX. This makes the architectural state visible off-chip without hierarchical probing.

## Interface
- `DATA_WIDTH`, 32, word width; fixed at 32.
- `MEM_ADDR_WIDTH`, 8, data-memory word-address width.
- `MEM_DUMP_WORDS`, 32, number of memory words dumped, starting at word 0; must be ≥1 and ≤2^MEM_ADDR_WIDTH.
- `HEADER_BYTE`, 8'hA5, first byte of every frame.

- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_halt`  in  1  core halt flag.
- `i_pc`  in  32  current PC, sampled live.
- `o_reg_addr`  out  5  register-file read address.
- `i_reg_data`  in  32  register-file read data; valid one cycle after `o_reg_addr`.
- `o_mem_addr`  out  MEM_ADDR_WIDTH  data-memory word read address.
- `i_mem_data`  in  32  memory read data; valid one cycle after `o_mem_addr`.
- `o_tx_data`  out  8  stream byte.
- `o_tx_valid`  out  1  byte valid.
- `i_tx_ready`  in  1  sink ready.
- `o_busy`  out  1  high from HEADER through CHECKSUM.
- `o_done`  out  1  high in DONE.

## Operation
- Cycle counter (32 bit):
  - Increments every clock while `i_halt`=0.
  - Frozen while `i_halt`=1.
  - Saturates at 0xFFFFFFFF.
  - Never cleared except by reset.
- Trigger: a registered copy `halt_q` (reset 0) is kept. A start occurs when `i_halt`=1 and `halt_q`=0. Consequently, `i_halt` already high after reset triggers a dump.
- Frame byte order:
  - `HEADER_BYTE`.
  - Word 0: cycle count.
  - Word 1: PC.
  - Words 2..33: r0..r31.
  - Words 34..33+MEM_DUMP_WORDS: mem[0..].
  - Checksum byte.
- Every word is sent as 4 bytes, MSB first.
- Checksum = XOR of all bytes after the header, excluding the checksum itself.
- Frame length = 138 + 4·MEM_DUMP_WORDS bytes (266 at default).
- FSM:
  - IDLE: on start → HEADER.
  - HEADER: drive the header byte with valid; on transfer → ADDR.
  - ADDR: drive `o_reg_addr`/`o_mem_addr` for the current word (1 cycle) → CAPTURE.
  - CAPTURE: latch the word into a 32-bit shift buffer. Cycle count and PC are latched directly from the counter and `i_pc`. → SEND.
  - SEND: present 4 bytes. After the 4th transfer, go to ADDR, or to CHECKSUM after the last word.
  - CHECKSUM: on transfer → DONE.
  - DONE: `o_done`=1; leave to IDLE when `i_halt`=0.
- Handshake: a byte transfers on a rising edge with `o_tx_valid`=1 and `i_tx_ready`=1.
  - Once valid is asserted, `o_tx_valid` and `o_tx_data` hold unchanged until transfer.
  - `o_tx_valid`=0 in IDLE, ADDR, CAPTURE and DONE.
- `i_halt` falling during a dump: the dump completes. DONE lasts exactly one cycle if `i_halt` is already 0.
- `i_halt` rising again while busy or in DONE: ignored. Only a rising edge seen in IDLE starts a frame.
- Address outputs hold their last value outside ADDR/CAPTURE.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE.
  - `o_tx_data`=0, `o_tx_valid`=0, `o_reg_addr`=0, `o_mem_addr`=0, `o_busy`=0, `o_done`=0.
  - Counter = 0, `halt_q`=0.
  - Any in-flight frame is abandoned, with no partial-frame recovery.
- Start is detected at edge T; HEADER (valid=1, busy=1) is visible after edge T.
- With `i_tx_ready` constantly 1:
  - Each word takes 6 cycles.
  - The frame occupies 2 + 6·(34+MEM_DUMP_WORDS) cycles: 398 at default.
  - `o_done` rises on the following edge.
- Read-port contract: the data input is sampled in CAPTURE, exactly one cycle after the address is driven in ADDR.

## Test plan
- Reset values: hold `reset_n`=0 mid-clock → all outputs 0 immediately. Release with `i_halt`=0 → `o_tx_valid` stays 0 and the counter increments from 0.
- Nominal dump:
  - Stimulus: 90 running cycles; regs r1=10, r2=20, r4=30, r6=-31, mem[0]=0x12345678; then raise `i_halt`; ready=1.
  - Required: 266 bytes.
    - Byte 0 = A5, bytes 1-4 = 00 00 00 5A.
    - r4 bytes = 00 00 00 1E; r6 bytes = FF FF FF E1; mem[0] bytes = 12 34 56 78.
    - Checksum correct.
  - `o_done`=1 398 cycles after the start edge.
- Backpressure: `i_tx_ready` high only every 3rd cycle, plus a random pattern → identical 266-byte stream. Data is stable while valid && !ready, with no drop or duplicate.
- Halt drop: lower `i_halt` at byte 40 → frame completes; `o_done` high for exactly 1 cycle; return to IDLE.
- Mid-frame reset: assert `reset_n`=0 at byte 50 while `i_halt`=1 → valid drops asynchronously. After release, a new frame starts with A5 and cycle-count bytes 00 00 00 00.
- Re-arm:
  - After DONE, lower `i_halt`, run 5 cycles, raise it again → second frame has cycle count = previous + 5 + 1.
  - A halt edge during busy produces no extra frame.
